rf_wb_queue: RTL and testbench

Writeback merge stage that sits directly upstream of the CPU register file and drives its single write port (en_write, w_addr, datain). ALU results are one-cycle, always-accepted writebacks. Data-memory load returns arrive late with a valid/ready handshake and are buffered in a small FIFO. The FIFO drains into the write port only in cycles the ALU path leaves idle. A combinational check port lets the decode stage detect registers with pending queued writes and forward the youngest queued value.

---
 rtl/rf_wb_queue.sv | 85 ++++++++
 tb/tb_rf_wb_queue.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: register-file writeback merge of always-accepted ALU results with a queued load-return FIFO
module rf_wb_queue #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDRWIDTH-1:0]       alu_rd,
  input  logic [DATAWIDTH-1:0]       alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDRWIDTH-1:0]       ld_rd,
  input  logic [DATAWIDTH-1:0]       ld_data,
  output logic                       wb_en,
  output logic [ADDRWIDTH-1:0]       wb_addr,
  output logic [DATAWIDTH-1:0]       wb_data,
  input  logic [ADDRWIDTH-1:0]       chk_addr,
  output logic                       chk_hit,
  output logic [DATAWIDTH-1:0]       chk_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDRWIDTH-1:0] rd_q [DEPTH];
  logic [DATAWIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]     live;
  logic [PW-1:0]        wptr, rptr, idx;
  logic                 alu_eff, push, pop;
  assign alu_eff  = alu_valid && alu_rd != '0;
  assign ld_ready = count < CW'(DEPTH);
  assign push     = ld_valid && ld_ready && ld_rd != '0;
  assign pop      = !alu_eff && count != '0;
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= ld_rd;
      data_q[wptr] <= ld_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live    <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_eff && rd_q[i] == alu_rd) live[i] <= 1'b0;
      if (pop) live[rptr] <= 1'b0;
      // a load racing an ALU write to the same register is born dead
      if (push) live[wptr] <= !(alu_eff && ld_rd == alu_rd);
      wptr  <= push ? wptr + 1'b1 : wptr;
      rptr  <= pop ? rptr + 1'b1 : rptr;
      count <= count + CW'(push) - CW'(pop);
      if (alu_eff) begin
        wb_en   <= 1'b1;
        wb_addr <= alu_rd;
        wb_data <= alu_data;
      end else if (pop && live[rptr]) begin
        wb_en   <= 1'b1;
        wb_addr <= rd_q[rptr];
        wb_data <= data_q[rptr];
      end else begin
        wb_en <= 1'b0;
      end
    end
  end
  // walk oldest to youngest so the last match is the youngest
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (chk_addr != '0 && CW'(k) < count && live[idx] && rd_q[idx] == chk_addr) begin
        chk_hit  = 1'b1;
        chk_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed self-checking bench for rf_wb_queue
module tb_rf_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, ld_ready, wb_en, chk_hit;
  logic [4:0]  alu_rd, ld_rd, wb_addr, chk_addr;
  logic [31:0] alu_data, ld_data, wb_data, chk_data;
  logic [2:0]  count;
  int checks = 0;
  int failures = 0;

  rf_wb_queue #(.DATAWIDTH(32), .ADDRWIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_en"}, 32'(wb_en), 32'(en));
    chk({tag, "_addr"}, 32'(wb_addr), 32'(a));
    chk({tag, "_data"}, wb_data, d);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; chk_addr = 0;
    tick(); tick();
    wb("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(ld_ready), 32'd1);
    rst = 1'b1;

    alu_valid = 1; alu_rd = 5; alu_data = 32'hA5A5_0001;
    tick();
    wb("alu5", 1'b1, 5'd5, 32'hA5A5_0001);
    alu_rd = 0; alu_data = 32'hDEAD_BEEF;
    tick();
    wb("alu0", 1'b0, 5'd5, 32'hA5A5_0001);

    alu_rd = 20;
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h100 + 32'(i);
      ld_rd = 5'(i + 1); ld_data = 32'h10 + 32'(i);
      tick();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(ld_ready), 32'd0);
    wb("fill_alu", 1'b1, 5'd20, 32'h103);
    ld_rd = 5; ld_data = 32'h14; alu_data = 32'h104;
    tick();
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_ready", 32'(ld_ready), 32'd0);
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wb($sformatf("drain%0d", i), 1'b1, 5'(i + 1), 32'h10 + 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(3 - i));
      chk($sformatf("drain%0d_ready", i), 32'(ld_ready), 32'd1);
    end
    tick();
    wb("drain_idle", 1'b0, 5'd4, 32'h13);

    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    tick();
    ld_valid = 0; chk_addr = 7; #1;
    chk("kill_pre_cnt", 32'(count), 32'd1);
    chk("kill_pre_hit", 32'(chk_hit), 32'd1);
    chk("kill_pre_data", chk_data, 32'h77);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h99;
    tick();
    wb("kill_alu", 1'b1, 5'd7, 32'h99);
    chk("kill_hit", 32'(chk_hit), 32'd0);
    chk("kill_data", chk_data, 32'h0);
    chk("kill_cnt", 32'(count), 32'd1);
    alu_valid = 0;
    tick();
    wb("kill_pop", 1'b0, 5'd7, 32'h99);
    chk("kill_pop_cnt", 32'(count), 32'd0);

    ld_valid = 1; ld_rd = 9; ld_data = 32'h55;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h66; chk_addr = 9;
    tick();
    wb("same_alu", 1'b1, 5'd9, 32'h66);
    chk("same_cnt", 32'(count), 32'd1);
    chk("same_hit", 32'(chk_hit), 32'd0);
    ld_valid = 0; alu_valid = 0;
    tick();
    wb("same_pop", 1'b0, 5'd9, 32'h66);
    chk("same_pop_cnt", 32'(count), 32'd0);

    alu_valid = 1; alu_rd = 20; alu_data = 32'h200;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h1;
    tick();
    ld_data = 32'h2;
    tick();
    ld_rd = 6; ld_data = 32'h3;
    tick();
    ld_valid = 0;
    chk_addr = 3; #1;
    chk("fwd_cnt", 32'(count), 32'd3);
    chk("fwd_hit", 32'(chk_hit), 32'd1);
    chk("fwd_data", chk_data, 32'h2);
    chk_addr = 6; #1;
    chk("fwd6_data", chk_data, 32'h3);
    chk_addr = 0; #1;
    chk("fwd0_hit", 32'(chk_hit), 32'd0);
    chk("fwd0_data", chk_data, 32'h0);
    chk_addr = 4; #1;
    chk("fwd4_hit", 32'(chk_hit), 32'd0);
    chk("arst_pre_en", 32'(wb_en), 32'd1);

    alu_valid = 0; chk_addr = 3;
    #1 rst = 1'b0;
    #1;
    wb("arst", 1'b0, 5'd0, 32'h0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_hit", 32'(chk_hit), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_en%0d", i), 32'(wb_en), 32'd0);
      chk($sformatf("post_cnt%0d", i), 32'(count), 32'd0);
    end
    chk("post_ready", 32'(ld_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
